matrix_add_seq: RTL and testbench

//  Time-multiplexed sequencer for the 8-pair, 16-bit matrix adder datapath.
//  - Streams operand pairs in over a valid/ready handshake and forms each sum with one shared W-bit adder.
//  - Packs the sums into one N*W-bit result word, first pair in the MSB slice.
//  - Presents the word downstream with valid/ready.
//  - Sits between the operand fetch logic and the result consumer.

---
 rtl/matrix_add_seq.sv | 113 +++++++++++
 tb/tb_matrix_add_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_add_seq.sv
// Time-multiplexed matrix adder: streams N operand pairs through one shared W-bit adder
// and packs the sums into an N*W-bit word (pair 0 in the MSB slice). Optional: MATRIX_ADD_SAT_EN.
module matrix_add_seq #(
    parameter int W = 16,
    parameter int N = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_a,
    input  logic [W-1:0]             in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N*W-1:0]           out,
`ifdef MATRIX_ADD_SAT_EN
    output logic                     sat_flag,
`endif
    output logic                     busy,
    output logic [$clog2(N+1)-1:0]   pair_cnt
);

    localparam int CW = $clog2(N+1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_e;

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic [N*W-1:0] out_q;
    logic [W-1:0]   sum_d;
    logic           xfer;
    logic           last;

    assign xfer = in_valid && in_ready;
    assign last = (cnt_q == CW'(N - 1));

`ifdef MATRIX_ADD_SAT_EN
    logic [W:0] wide_sum;
    logic       sat_d;
    logic       sat_q;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        wide_sum = {1'b0, in_a} + {1'b0, in_b};
        sat_d    = wide_sum[W];
        sum_d    = sat_d ? {W{1'b1}} : wide_sum[W-1:0];
    end

    assign sat_flag = sat_q;
`else
    assign sum_d = in_a + in_b;
`endif

    // NOTE: state lives in one always_ff using non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            // NOTE: the result word is reset as well because it is visible on out and must read 0.
            out_q   <= '0;
`ifdef MATRIX_ADD_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else if (clr) begin
            // Flush drops the partial word but leaves the previously written slices alone.
            state_q <= IDLE;
            cnt_q   <= '0;
`ifdef MATRIX_ADD_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, LOAD: begin
                    if (xfer) begin
                        for (int k = 0; k < N; k++) begin
                            if (cnt_q == CW'(k)) begin
                                out_q[(N-k)*W-1 -: W] <= sum_d;
                            end
                        end
                        cnt_q   <= cnt_q + 1'b1;
                        state_q <= last ? DONE : LOAD;
`ifdef MATRIX_ADD_SAT_EN
                        sat_q   <= (state_q == IDLE) ? sat_d : (sat_q | sat_d);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Handshake and status flags decode straight from the state register.
    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out       = out_q;
    assign pair_cnt  = cnt_q;

endmodule

// File: tb/tb_matrix_add_seq.sv
// Directed self-checking bench for matrix_add_seq (default build, wrap-around sums).
// Inputs change 1 ns after each rising edge; outputs are sampled at that same point.
module tb_matrix_add_seq;

    localparam int W = 16;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           clr;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out;
    logic           busy;
    logic [3:0]     pair_cnt;

    int checks = 0;
    int errors = 0;

    logic [N*W-1:0] held;

    matrix_add_seq #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy),
        .pair_cnt  (pair_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pair_cnt", pair_cnt, 0);
        check("rst_out", out, 0);
        check("rst_in_ready", in_ready, 1);

        // Back-to-back word, a=i, b=0x0100*i
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_a     = W'(i);
            in_b     = W'(i * 16'h0100);
            tick();
            check("b2b_pair_cnt", pair_cnt, i);
            check("b2b_busy", busy, 1);
            check("b2b_out_valid", out_valid, (i == 8) ? 1 : 0);
        end
        check("b2b_out", out, 128'h0101_0202_0303_0404_0505_0606_0707_0808);
        check("b2b_in_ready_done", in_ready, 0);

        // Backpressure in DONE with the next (overflowing) pair already offered
        in_valid = 1'b1;
        in_a     = 16'hFFFF;
        in_b     = 16'h0002;
        held     = out;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_in_ready", in_ready, 0);
            check("bp_out_stable", out, held);
            check("bp_pair_cnt", pair_cnt, 8);
            check("bp_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hs_out_valid", out_valid, 0);
        check("hs_pair_cnt", pair_cnt, 0);
        check("hs_busy", busy, 0);
        check("hs_in_ready", in_ready, 1);
        check("hs_out_kept", out, held);
        tick();
        in_valid = 1'b0;
        check("bubble_accept_cnt", pair_cnt, 1);
        check("overflow_wrap", out[127:112], 16'h0001);

        // Gapped input for the rest of that word: a=b=j
        for (int j = 1; j <= 7; j++) begin
            in_valid = 1'b0;
            tick();
            check("gap_idle_cnt", pair_cnt, j);
            in_valid = 1'b1;
            in_a     = W'(j);
            in_b     = W'(j);
            tick();
            check("gap_xfer_cnt", pair_cnt, j + 1);
        end
        in_valid = 1'b0;
        check("gap_out_valid", out_valid, 1);
        check("gap_out", out, 128'h0001_0002_0004_0006_0008_000A_000C_000E);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("gap_hs_cnt", pair_cnt, 0);

        // Flush after 3 pairs
        for (int p = 0; p < 3; p++) send(16'h0010, 16'h0001);
        check("pre_clr_cnt", pair_cnt, 3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_pair_cnt", pair_cnt, 0);
        check("clr_out_valid", out_valid, 0);
        check("clr_busy", busy, 0);
        check("clr_in_ready", in_ready, 1);
        check("clr_out_unchanged", out, 128'h0011_0011_0011_0006_0008_000A_000C_000E);

        // Fresh word completes normally after the flush
        for (int p = 0; p < 8; p++) begin
            in_valid = 1'b1;
            in_a     = 16'h1000;
            in_b     = W'(p);
            tick();
        end
        in_valid = 1'b0;
        check("post_clr_out_valid", out_valid, 1);
        check("post_clr_out", out, 128'h1000_1001_1002_1003_1004_1005_1006_1007);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset mid-word clears the result register
        for (int p = 0; p < 3; p++) send(16'h0020, 16'h0003);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_out", out, 0);
        check("rst_mid_cnt", pair_cnt, 0);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_busy", busy, 0);

        // clr wins over a simultaneous transfer, in LOAD and in IDLE
        send(16'h0005, 16'h0005);
        send(16'h0005, 16'h0005);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_a     = 16'h7777;
        in_b     = 16'h0000;
        tick();
        check("clr_xfer_load_cnt", pair_cnt, 0);
        check("clr_xfer_load_busy", busy, 0);
        check("clr_xfer_dropped", out, 128'h000A_000A_0000_0000_0000_0000_0000_0000);
        tick();
        check("clr_xfer_idle_cnt", pair_cnt, 0);
        check("clr_xfer_idle_out", out[127:112], 16'h000A);
        clr      = 1'b0;
        in_valid = 1'b0;

        // rst and clr together give reset values
        send(16'h0001, 16'h0001);
        check("pre_rstclr_cnt", pair_cnt, 1);
        rst = 1'b1;
        clr = 1'b1;
        tick();
        rst = 1'b0;
        clr = 1'b0;
        check("rstclr_out", out, 0);
        check("rstclr_cnt", pair_cnt, 0);
        check("rstclr_out_valid", out_valid, 0);
        check("rstclr_in_ready", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
